// File: rtl/cpu_job_arbiter_if.sv
// Bundle of the two requester ports, the response port and the CPU-side bus.
// master = arbiter side, slave = requesters plus CPU.
interface cpu_job_arbiter_if #(
    parameter int DW = 16
);
    logic          req0_valid;
    logic          req0_ready;
    logic [DW-1:0] req0_instr;
    logic [DW-1:0] req0_imm;
    logic          req0_has_imm;
    logic          req1_valid;
    logic          req1_ready;
    logic [DW-1:0] req1_instr;
    logic [DW-1:0] req1_imm;
    logic          req1_has_imm;
    logic          resp_valid;
    logic          resp_id;
    logic [DW-1:0] resp_data;
    logic          resp_err;
    logic          cpu_run;
    logic [DW-1:0] cpu_din;
    logic [DW-1:0] cpu_dout;
    logic          cpu_done;
    logic          busy;

    modport master (
        input  req0_valid, req0_instr, req0_imm, req0_has_imm,
        input  req1_valid, req1_instr, req1_imm, req1_has_imm,
        input  cpu_dout, cpu_done,
        output req0_ready, req1_ready,
        output resp_valid, resp_id, resp_data, resp_err,
        output cpu_run, cpu_din, busy
    );

    modport slave (
        output req0_valid, req0_instr, req0_imm, req0_has_imm,
        output req1_valid, req1_instr, req1_imm, req1_has_imm,
        output cpu_dout, cpu_done,
        input  req0_ready, req1_ready,
        input  resp_valid, resp_id, resp_data, resp_err,
        input  cpu_run, cpu_din, busy
    );
endinterface

// File: rtl/cpu_job_arbiter.sv
// Round-robin front end sharing one CPU core between two requesters; issues
// instruction then optional immediate, waits for done with a watchdog, returns result.
module cpu_job_arbiter #(
    parameter int DW      = 16,
    parameter int TIMEOUT = 15,
    parameter int TW      = 4
) (
    input  logic               clk,
    input  logic               resetn,
    cpu_job_arbiter_if.master  bus,
    output logic [1:0]         dbg_state
);
    // Handshake: a job transfers on a rising edge where reqN_valid & reqN_ready;
    // ready is only offered in IDLE, and only to the requester picked this cycle.
    typedef enum logic [1:0] {IDLE = 2'd0, ISSUE = 2'd1, WAIT = 2'd2, RESP = 2'd3} state_t;

    state_t        state, state_nxt;
    logic          last_grant;
    logic [TW-1:0] wd;
    logic [DW-1:0] job_instr, job_imm;
    logic          job_has_imm, job_id;
    logic [DW-1:0] resp_data_q;
    logic          resp_err_q, resp_id_q;
    logic          grant0, grant1, hs0, hs1, wd_expired;

    // On a tie the requester that did not own the previous job wins.
    assign grant0     = bus.req0_valid && (!bus.req1_valid || last_grant);
    assign grant1     = bus.req1_valid && (!bus.req0_valid || !last_grant);
    assign wd_expired = (wd == TW'(TIMEOUT - 1));
    assign hs0        = bus.req0_valid && bus.req0_ready;
    assign hs1        = bus.req1_valid && bus.req1_ready;

    assign bus.resp_id   = resp_id_q;
    assign bus.resp_data = resp_data_q;
    assign bus.resp_err  = resp_err_q;
    assign bus.busy      = (state != IDLE);
    assign dbg_state     = state;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt      = state;
        bus.req0_ready = 1'b0;
        bus.req1_ready = 1'b0;
        bus.cpu_run    = 1'b0;
        bus.cpu_din    = '0;
        bus.resp_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.req0_ready = grant0;
                bus.req1_ready = grant1;
                if (grant0 || grant1) state_nxt = ISSUE;
            end
            ISSUE: begin
                bus.cpu_run = 1'b1;
                bus.cpu_din = job_instr;
                state_nxt   = WAIT;
            end
            WAIT: begin
                bus.cpu_din = job_has_imm ? job_imm : job_instr;
                if (bus.cpu_done || wd_expired) state_nxt = RESP;
            end
            RESP: begin
                bus.resp_valid = 1'b1;
                state_nxt      = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            last_grant  <= 1'b1;
            wd          <= '0;
            job_instr   <= '0;
            job_imm     <= '0;
            job_has_imm <= 1'b0;
            job_id      <= 1'b0;
            resp_data_q <= '0;
            resp_err_q  <= 1'b0;
            resp_id_q   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (hs0 || hs1) begin
                        job_instr   <= hs1 ? bus.req1_instr   : bus.req0_instr;
                        job_imm     <= hs1 ? bus.req1_imm     : bus.req0_imm;
                        job_has_imm <= hs1 ? bus.req1_has_imm : bus.req0_has_imm;
                        job_id      <= hs1;
                        wd          <= '0;
                    end
                end
                WAIT: begin
                    wd <= wd + 1'b1;
                    // A done arriving on the last allowed cycle still counts as success.
                    if (bus.cpu_done) begin
                        resp_data_q <= bus.cpu_dout;
                        resp_err_q  <= 1'b0;
                        resp_id_q   <= job_id;
                    end else if (wd_expired) begin
                        resp_data_q <= '0;
                        resp_err_q  <= 1'b1;
                        resp_id_q   <= job_id;
                    end
                end
                RESP: last_grant <= job_id;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cpu_job_arbiter.sv
// Scoreboard bench for cpu_job_arbiter: a CPU model answers Run after a set
// delay; expected responses are queued at accept time and popped on resp_valid.
module tb_cpu_job_arbiter;
    localparam int DW = 16;
    localparam int EW = DW + 8;

    logic clk;
    logic resetn;
    logic [1:0] dbg_state;

    cpu_job_arbiter_if #(.DW(DW)) bus ();

    cpu_job_arbiter #(.DW(DW), .TIMEOUT(15), .TW(4)) dut (
        .clk      (clk),
        .resetn   (resetn),
        .bus      (bus),
        .dbg_state(dbg_state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    // CPU model configuration (written only by the stimulus process)
    int          cfg_delay = 2;
    logic [DW-1:0] cfg_dout = '0;
    bit          cfg_issue_done = 1'b0;
    int          run_age = -1;

    always @(posedge clk) begin
        #1;
        if (!resetn) begin
            run_age      = -1;
            bus.cpu_done = 1'b0;
        end else begin
            if (bus.cpu_run) run_age = 0;
            else if (run_age >= 0) run_age++;
            bus.cpu_done = (bus.cpu_run && cfg_issue_done) || (run_age > 0 && run_age == cfg_delay);
        end
        bus.cpu_dout = cfg_dout;
    end

    // Scoreboard, entries packed as {wait_len[5:0], id, err, data}
    logic [EW-1:0] exp_q[$];
    logic [EW-1:0] e;
    bit            tb_last = 1'b1;
    logic [DW-1:0] cur_instr, cur_imm;
    bit            cur_has_imm;
    int            run_cnt, wait_cnt;
    int            hs_cnt = 0;
    int            resp_cnt = 0;

    always @(negedge clk) begin
        if (!resetn) begin
            exp_q.delete();
            tb_last = 1'b1;
        end else begin
            automatic bit v0  = bus.req0_valid;
            automatic bit v1  = bus.req1_valid;
            automatic bit eg0 = v0 && (!v1 || tb_last);
            automatic bit eg1 = v1 && (!v0 || !tb_last);
            if (!bus.busy) begin
                check("ready0", bus.req0_ready, eg0);
                check("ready1", bus.req1_ready, eg1);
                if (eg0 || eg1) begin
                    automatic int wl = (cfg_delay >= 1 && cfg_delay <= 15) ? cfg_delay : 15;
                    automatic bit er = !(cfg_delay >= 1 && cfg_delay <= 15);
                    automatic logic [DW-1:0] dat = er ? '0 : cfg_dout;
                    exp_q.push_back({6'(wl), eg1, er, dat});
                    cur_instr   = eg1 ? bus.req1_instr   : bus.req0_instr;
                    cur_imm     = eg1 ? bus.req1_imm     : bus.req0_imm;
                    cur_has_imm = eg1 ? bus.req1_has_imm : bus.req0_has_imm;
                    run_cnt  = 0;
                    wait_cnt = 0;
                    hs_cnt++;
                end
            end else begin
                if (bus.req0_ready || bus.req1_ready) check("ready_when_busy", 1, 0);
                if (bus.cpu_run) begin
                    run_cnt++;
                    check("din_issue", bus.cpu_din, cur_instr);
                end else if (!bus.resp_valid) begin
                    wait_cnt++;
                    check("din_wait", bus.cpu_din, cur_has_imm ? cur_imm : cur_instr);
                end
                if (bus.resp_valid) begin
                    resp_cnt++;
                    if (exp_q.size() == 0) begin
                        check("unexpected_resp", 1, 0);
                    end else begin
                        e = exp_q.pop_front();
                        check("resp_id",   bus.resp_id,   e[DW+1]);
                        check("resp_err",  bus.resp_err,  e[DW]);
                        check("resp_data", bus.resp_data, e[DW-1:0]);
                        check("wait_len",  wait_cnt,      e[EW-1:DW+2]);
                        check("run_pulses", run_cnt,      1);
                        tb_last = e[DW+1];
                    end
                end
            end
        end
    end

    task automatic set_req(input bit id, input bit v, input logic [DW-1:0] instr,
                           input logic [DW-1:0] imm, input bit has_imm);
        if (id) begin
            bus.req1_valid = v; bus.req1_instr = instr; bus.req1_imm = imm; bus.req1_has_imm = has_imm;
        end else begin
            bus.req0_valid = v; bus.req0_instr = instr; bus.req0_imm = imm; bus.req0_has_imm = has_imm;
        end
    endtask

    task automatic wait_hs(input int base);
        int n = 0;
        do begin
            @(posedge clk); #1; n++;
        end while (hs_cnt <= base && n < 50);
        if (hs_cnt <= base) check("hs_timeout", 0, 1);
    endtask

    task automatic wait_resp(input int target, input int budget);
        int n = 0;
        while (resp_cnt < target && n < budget) begin
            @(posedge clk); #1; n++;
        end
        if (resp_cnt < target) check("resp_timeout", resp_cnt, target);
    endtask

    task automatic send(input bit id, input logic [DW-1:0] instr, input logic [DW-1:0] imm,
                        input bit has_imm, input int delay, input logic [DW-1:0] dout, input bit issue_done);
        int base = hs_cnt;
        int target = resp_cnt + 1;
        cfg_delay = delay; cfg_dout = dout; cfg_issue_done = issue_done;
        set_req(id, 1'b1, instr, imm, has_imm);
        wait_hs(base);
        set_req(id, 1'b0, $urandom_range(0, 16'hFFFF), $urandom_range(0, 16'hFFFF), 1'b0);
        wait_resp(target, 60);
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1;
    endtask

    task automatic both_valid(input int jobs, input int delay, input logic [DW-1:0] dout);
        int target = resp_cnt + jobs;
        cfg_delay = delay; cfg_dout = dout; cfg_issue_done = 1'b0;
        set_req(0, 1'b1, 16'h0100, 16'h0000, 1'b0);
        set_req(1, 1'b1, 16'h0200, 16'h2222, 1'b1);
        wait_resp(target, 40 * jobs);
        set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_req(1, 1'b0, 16'h0, 16'h0, 1'b0);
        @(posedge clk); #1;
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_resp_valid"}, bus.resp_valid, 0);
        check({tag, "_resp_id"},    bus.resp_id,    0);
        check({tag, "_resp_data"},  bus.resp_data,  0);
        check({tag, "_resp_err"},   bus.resp_err,   0);
        check({tag, "_cpu_run"},    bus.cpu_run,    0);
        check({tag, "_cpu_din"},    bus.cpu_din,    0);
        check({tag, "_busy"},       bus.busy,       0);
        check({tag, "_ready0"},     bus.req0_ready, 0);
        check({tag, "_ready1"},     bus.req1_ready, 0);
        check({tag, "_state"},      dbg_state,      0);
    endtask

    initial begin
        resetn = 1'b0;
        set_req(0, 1'b0, 16'h0, 16'h0, 1'b0);
        set_req(1, 1'b0, 16'h0, 16'h0, 1'b0);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        #2 resetn = 1'b1;
        repeat (2) @(posedge clk);
        #1;

        send(0, 16'h0011, 16'h0000, 1'b0, 2,    16'h00A5, 1'b0);
        send(1, 16'h0040, 16'h1234, 1'b1, 3,    16'h5A5A, 1'b0);
        both_valid(4, 2, 16'h0C0C);
        send(0, 16'h0077, 16'h0000, 1'b0, 1000, 16'hDEAD, 1'b0);
        send(1, 16'h0033, 16'h0000, 1'b0, 1,    16'h0001, 1'b0);
        send(0, 16'h0055, 16'h9999, 1'b1, 15,   16'hBEEF, 1'b1);
        for (int i = 0; i < 3; i++)
            send(i[0], 16'($urandom_range(0, 16'hFFFF)), 16'($urandom_range(0, 16'hFFFF)),
                 1'($urandom_range(0, 1)), $urandom_range(1, 15), 16'($urandom_range(0, 16'hFFFF)), 1'b0);

        // Abandon a job mid-WAIT with an asynchronous reset
        cfg_delay = 1000; cfg_dout = 16'h7777; cfg_issue_done = 1'b0;
        begin
            int base = hs_cnt;
            set_req(1, 1'b1, 16'h0066, 16'h0000, 1'b0);
            wait_hs(base);
            set_req(1, 1'b0, 16'h0, 16'h0, 1'b0);
        end
        repeat (5) @(posedge clk);
        #2 resetn = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (3) @(posedge clk);
        #3 resetn = 1'b1;
        @(posedge clk); #1;
        both_valid(2, 2, 16'h4321);

        repeat (4) @(posedge clk);
        check("queue_empty", exp_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/cpu_job_arbiter.md
Name: cpu_job_arbiter

Overview:
- Front-end scheduler that shares the single 16-bit CPU core between two instruction requesters.
- Accepts one job at a time using a round-robin valid/ready handshake.
- Sequences the CPU's Run/dataIn inputs: instruction word, then optional immediate word. It waits for done, captures the bus result and returns it to the owning requester.
- A watchdog aborts jobs whose done never arrives.

Parameters:
- DW, 16, data/instruction word width (matches CPU bus)
- TIMEOUT, 15, max WAIT cycles before abort (1..2^TW-1)
- TW, 4, watchdog counter width

Ports:
- clk  input  1  system clock, rising edge
- resetn  input  1  asynchronous active-low reset
- req0_valid  input  1  requester 0 has a job
- req0_ready  output  1  requester 0 job accepted this cycle
- req0_instr  input  DW  requester 0 instruction word
- req0_imm  input  DW  requester 0 immediate word
- req0_has_imm  input  1  requester 0 job carries an immediate
- req1_valid / req1_ready / req1_instr / req1_imm / req1_has_imm: same as requester 0, for requester 1
- resp_valid  output  1  one-cycle response strobe
- resp_id  output  1  owner of the response (0/1)
- resp_data  output  DW  captured CPU bus value
- resp_err  output  1  job aborted by watchdog
- cpu_run  output  1  drives CPU Run
- cpu_din  output  DW  drives CPU dataIn
- cpu_dout  input  DW  CPU dataOut (bus)
- cpu_done  input  1  CPU done
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (asynchronous, resetn=0):
  - State = IDLE.
  - All outputs 0: resp_valid, resp_id, resp_data, resp_err, cpu_run, cpu_din, busy, req*_ready.
  - last_grant = 1, so requester 0 wins the first tie.
  - Watchdog = 0, job latches = 0.
  - Reset mid-job abandons the job silently; no response is produced.
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - cpu_din = 0, cpu_run = 0.
  - Grant is combinational:
    - Only one valid: grant that requester.
    - Both valid: grant the requester not equal to last_grant.
  - reqN_ready = 1 only for the granted requester, only in IDLE. Handshake = valid & ready.
  - On handshake: latch instr, imm, has_imm and id; clear watchdog; next state ISSUE.
  - No valid: stay in IDLE.
  - Changing valid or data while ready=0 has no effect.
- ISSUE (exactly 1 cycle):
  - cpu_run = 1, cpu_din = latched instr.
  - cpu_done is ignored in this cycle.
  - Next state WAIT.
- WAIT:
  - cpu_run = 0.
  - cpu_din = latched imm if has_imm, else latched instr (held stable).
  - Watchdog increments every WAIT cycle.
  - cpu_done = 1 sampled: resp_data <= cpu_dout, resp_err <= 0, next state RESP.
    - If done and watchdog reaching TIMEOUT coincide, done wins (no error).
  - Watchdog == TIMEOUT-1 and cpu_done = 0: resp_data <= 0, resp_err <= 1, next state RESP. WAIT therefore lasts at most TIMEOUT cycles.
- RESP (exactly 1 cycle):
  - resp_valid = 1, resp_id = latched id; resp_data and resp_err hold captured values.
  - last_grant <= latched id; next state IDLE.
  - No backpressure on the response.
  - resp_data, resp_err and resp_id hold their values after RESP until the next RESP.
- Latency:
  - Handshake at edge k → ISSUE in cycle k+1 → WAIT from k+2.
  - done seen at edge d → resp_valid in cycle d+1 → IDLE in d+2.
  - Minimum accept-to-accept spacing is 4 cycles.
- cpu_run is always a single-cycle pulse; it is never asserted twice for one job.
- A requester holding valid high across its own response re-competes under round-robin; it is not accepted twice back-to-back if the other requester is valid.
- busy = (state != IDLE).

Test Plan:
- Single job, no imm: req0 instr=0x0011; CPU model asserts done 2 cycles after Run with dout=0x00A5.
  - Required: cpu_run one pulse with cpu_din=0x0011; resp_valid one cycle later with id=0, data=0x00A5, err=0.
- Immediate job: req1 instr=0x0040, imm=0x1234, has_imm=1.
  - Required: cpu_din=0x0040 during ISSUE, 0x1234 throughout WAIT; response id=1.
- Fairness: both valid continuously after reset.
  - Required: grants alternate 0,1,0,1; neither requester ready twice in a row; every ready lies in IDLE only.
- Timeout: CPU model never asserts done.
  - Required: exactly 15 WAIT cycles, then resp_valid with err=1, data=0x0000; next job is accepted normally.
- Done at the limit: done asserted in the 15th WAIT cycle with dout=0xBEEF.
  - Required: err=0, data=0xBEEF. Also done asserted during ISSUE is ignored; only a later done completes the job.
- Async reset in WAIT: drop resetn mid-cycle.
  - Required: outputs go to 0 immediately, no resp_valid, state IDLE, and requester 0 wins the first tie after release.
